line_fill_memory: RTL and testbench

- Backing data memory that sits directly downstream of the cache controller.
- Services the controller's `MemRead_en` / `MemWrite_en` requests with a fixed, parameterised latency, then signals completion on `ready`.
- Reads return the whole 4-word line containing `address`, used for a cache fill. Writes update the single word at `address` (write-through / write-around traffic).
- Uses a four-phase handshake, so a request held high across the controller's stall is serviced exactly once.

---
 rtl/line_fill_memory.sv | 148 ++++++++++++++
 tb/tb_line_fill_memory.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_fill_memory.sv
// line_fill_memory
//
// Backing word memory sitting directly below the cache controller. A request
// is accepted in IDLE, serviced after a fixed LATENCY, and completion is
// signalled by a one-cycle `ready` pulse. Reads return the whole 4-word line
// that contains `address` (for a cache fill). Writes update a single word.
// A four-phase handshake (RESP -> RELEASE until both enables drop) ensures a
// request held high across a controller stall is serviced exactly once.
//
// Parameters:
//   ADDR_W   word-address width, storage depth is 2**ADDR_W words
//   DATA_W   word width
//   LATENCY  cycles from acceptance to `ready`, legal range 1..15
//
// Ports:
//   clock        in   single clock, all state changes on its rising edge
//   reset        in   synchronous active-high reset
//   address      in   word address: upper bits line, [1:0] word offset
//   MemRead_en   in   read-line request (level, held until `ready`)
//   MemWrite_en  in   write-word request (level), wins over a read
//   wdata        in   write data
//   ready        out  one-cycle completion pulse
//   rdata_line   out  last line read, word k at [k*DATA_W +: DATA_W]
//   busy         out  high whenever the block is not idle

module line_fill_memory #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   address,
  input  logic                MemRead_en,
  input  logic                MemWrite_en,
  input  logic [DATA_W-1:0]   wdata,
  output logic                ready,
  output logic [4*DATA_W-1:0] rdata_line,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP,
    RELEASE
  } state_t;

  localparam logic [3:0] COUNT_INIT = 4'(LATENCY - 1);

  state_t              state;
  state_t              next_state;
  logic [3:0]          count;
  logic                op_write;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                any_en;
  logic                accept;
  logic                finish;

  logic [DATA_W-1:0]   mem [0:(1<<ADDR_W)-1];

  assign any_en = MemRead_en | MemWrite_en;

  // Outputs are decoded from the registered state only, so no input can
  // reach them combinationally and `ready` is stable for a whole cycle.
  assign ready = (state == RESP);
  assign busy  = (state != IDLE);

  // State register; reset overrides any pending transition.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode. `accept` marks the IDLE edge that latches a request;
  // `finish` marks the BUSY->RESP edge on which the access takes effect.
  // RELEASE holds off new requests until the controller drops both enables.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (any_en) begin
          next_state = BUSY;
          accept     = 1'b1;
        end
      end
      BUSY: begin
        if (count == 4'd0) begin
          next_state = RESP;
          finish     = 1'b1;
        end
      end
      RESP: begin
        next_state = any_en ? RELEASE : IDLE;
      end
      RELEASE: begin
        if (!any_en) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Request latch, latency counter and read-line capture. Everything the
  // access needs is captured at acceptance so later input changes are
  // ignored. rdata_line only changes when a read completes.
  always_ff @(posedge clock) begin
    if (reset) begin
      count      <= 4'd0;
      op_write   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_line <= '0;
    end else begin
      if (accept) begin
        count    <= COUNT_INIT;
        op_write <= MemWrite_en;
        addr_q   <= address;
        wdata_q  <= wdata;
      end else if (state == BUSY && count != 4'd0) begin
        count <= count - 4'd1;
      end
      if (finish && !op_write) begin
        for (int k = 0; k < 4; k++) begin
          rdata_line[k*DATA_W +: DATA_W] <= mem[{addr_q[ADDR_W-1:2], 2'(k)}];
        end
      end
    end
  end

  // Storage array has no reset; a reset on the commit edge suppresses the
  // write so an interrupted request leaves memory untouched.
  always_ff @(posedge clock) begin
    if (!reset && finish && op_write) begin
      mem[addr_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_line_fill_memory.sv
// tb_line_fill_memory
//
// Self-checking bench for line_fill_memory (default parameters). A table of
// directed requests with constant expectations is applied first, followed by
// hand-written multi-cycle sequences (reset, held enable, aborted enable,
// input changes mid-request, mid-request reset) and finally randomized
// traffic compared against an array model of the memory.

module tb_line_fill_memory;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int LAT    = 4;

  logic                clock;
  logic                reset;
  logic [ADDR_W-1:0]   address;
  logic                MemRead_en;
  logic                MemWrite_en;
  logic [DATA_W-1:0]   wdata;
  logic                ready;
  logic [4*DATA_W-1:0] rdata_line;
  logic                busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          wr;
    logic [9:0]  addr;
    logic [31:0] data;
    int          slot;
    logic [31:0] exp_word;
  } vec_t;

  vec_t        vecs [9];
  logic [31:0] ref_mem [0:31];

  line_fill_memory #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .LATENCY (LAT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .address     (address),
    .MemRead_en  (MemRead_en),
    .MemWrite_en (MemWrite_en),
    .wdata       (wdata),
    .ready       (ready),
    .rdata_line  (rdata_line),
    .busy        (busy)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard stop in case the design wedges somewhere no bounded loop covers.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [127:0] actual,
                              input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Drives one request like the controller does: enables held until `ready`
  // is seen, then for extra_hold more cycles. Called and returns just after
  // a falling edge. lat is the number of rising edges from acceptance to the
  // first ready sample (-1 if none), pulses the ready samples in the window.
  task automatic apply_stimulus(input bit wr, input bit rd, input logic [9:0] a,
                                input logic [31:0] d, input int extra_hold,
                                input bit abort_early, input bit perturb,
                                output int lat, output int pulses,
                                output bit idle_at_end);
    address     = a;
    wdata       = d;
    MemWrite_en = wr;
    MemRead_en  = rd;
    lat         = -1;
    pulses      = 0;
    for (int i = 1; i <= LAT + extra_hold + 4; i++) begin
      @(negedge clock);
      if (ready === 1'b1) begin
        pulses++;
        if (lat < 0) lat = i - 1;
      end
      if (i == 1 && perturb) begin
        address = a ^ 10'h001;
        wdata   = ~d;
      end
      if ((i == 1 && abort_early) || (lat >= 0 && i - 1 >= lat + extra_hold)) begin
        MemWrite_en = 1'b0;
        MemRead_en  = 1'b0;
      end
    end
    MemWrite_en = 1'b0;
    MemRead_en  = 1'b0;
    idle_at_end = (busy === 1'b0);
  endtask

  task automatic check_handshake(input string name, input int lat, input int pulses,
                                 input bit idle_at_end);
    check_output({name, "_latency"}, 128'(lat), 128'(LAT));
    check_output({name, "_pulses"}, 128'(pulses), 128'd1);
    check_output({name, "_idle"}, 128'(idle_at_end), 128'd1);
  endtask

  task automatic write_word(input string name, input logic [9:0] a, input logic [31:0] d);
    int lat, pulses;
    bit idle;
    apply_stimulus(1'b1, 1'b0, a, d, 0, 1'b0, 1'b0, lat, pulses, idle);
    check_handshake(name, lat, pulses, idle);
  endtask

  task automatic read_word(input string name, input logic [9:0] a, input int slot,
                           input logic [31:0] exp_word);
    int lat, pulses;
    bit idle;
    apply_stimulus(1'b0, 1'b1, a, 32'h0, 0, 1'b0, 1'b0, lat, pulses, idle);
    check_handshake(name, lat, pulses, idle);
    check_output({name, "_word"}, 128'(rdata_line[slot*32 +: 32]), 128'(exp_word));
  endtask

  initial begin
    int lat, pulses, rdy_at, busy_low;
    bit idle;

    vecs[0] = '{1'b1, 10'h0A6, 32'hDEADBEEF, 0, 32'h0};
    vecs[1] = '{1'b0, 10'h0A4, 32'h0,        2, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 10'h031, 32'h11111111, 0, 32'h0};
    vecs[3] = '{1'b1, 10'h020, 32'hCAFEF00D, 0, 32'h0};
    vecs[4] = '{1'b1, 10'h2B0, 32'h0BADC0DE, 0, 32'h0};
    vecs[5] = '{1'b1, 10'h2B3, 32'h600DF00D, 0, 32'h0};
    vecs[6] = '{1'b0, 10'h2B1, 32'h0,        0, 32'h0BADC0DE};
    vecs[7] = '{1'b0, 10'h2B2, 32'h0,        3, 32'h600DF00D};
    vecs[8] = '{1'b0, 10'h020, 32'h0,        0, 32'hCAFEF00D};

    // Reset held for two edges with a read request pending.
    reset       = 1'b1;
    MemRead_en  = 1'b1;
    MemWrite_en = 1'b0;
    address     = '0;
    wdata       = '0;
    repeat (2) begin
      @(negedge clock);
      check_output("reset_ready", 128'(ready), 128'd0);
      check_output("reset_busy", 128'(busy), 128'd0);
      check_output("reset_rdata", rdata_line, 128'd0);
    end
    reset  = 1'b0;
    pulses = 0;
    rdy_at = -1;
    for (int k = 1; k <= LAT + 5; k++) begin
      @(negedge clock);
      if (ready === 1'b1) begin
        pulses++;
        if (rdy_at < 0) rdy_at = k;
        MemRead_en = 1'b0;
      end
    end
    MemRead_en = 1'b0;
    check_output("post_reset_ready_at", 128'(rdy_at), 128'(LAT + 1));
    check_output("post_reset_pulses", 128'(pulses), 128'd1);

    // Directed table of single requests.
    for (int v = 0; v < 9; v++) begin
      if (vecs[v].wr) begin
        write_word($sformatf("vec%0d_wr", v), vecs[v].addr, vecs[v].data);
      end else begin
        read_word($sformatf("vec%0d_rd", v), vecs[v].addr, vecs[v].slot, vecs[v].exp_word);
      end
    end

    // Both enables high: the write wins and rdata_line keeps the last line.
    apply_stimulus(1'b1, 1'b1, 10'h010, 32'h00000055, 0, 1'b0, 1'b0, lat, pulses, idle);
    check_handshake("both_en", lat, pulses, idle);
    check_output("both_en_rdata_kept", 128'(rdata_line[31:0]), 128'(32'hCAFEF00D));
    read_word("both_en_readback", 10'h010, 0, 32'h00000055);

    // Read enable held for 20 cycles: one service, busy until enable falls.
    address    = 10'h0A4;
    MemRead_en = 1'b1;
    pulses     = 0;
    busy_low   = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (ready === 1'b1) pulses++;
      if (busy !== 1'b1) busy_low++;
    end
    MemRead_en = 1'b0;
    @(negedge clock);
    check_output("held_pulses", 128'(pulses), 128'd1);
    check_output("held_busy_low_samples", 128'(busy_low), 128'd0);
    check_output("held_busy_after_drop", 128'(busy), 128'd0);
    check_output("held_rdata", 128'(rdata_line[95:64]), 128'(32'hDEADBEEF));

    // Write enable up for a single cycle still completes.
    apply_stimulus(1'b1, 1'b0, 10'h3FF, 32'h12345678, 0, 1'b1, 1'b0, lat, pulses, idle);
    check_handshake("abort", lat, pulses, idle);
    read_word("abort_readback", 10'h3FC, 3, 32'h12345678);

    // Address and data change during BUSY: latched values are used.
    apply_stimulus(1'b1, 1'b0, 10'h030, 32'hA5A5A5A5, 0, 1'b0, 1'b1, lat, pulses, idle);
    check_handshake("perturb", lat, pulses, idle);
    read_word("perturb_latched", 10'h030, 0, 32'hA5A5A5A5);
    check_output("perturb_neighbour", 128'(rdata_line[63:32]), 128'(32'h11111111));

    // Reset two edges after acceptance of a write discards it.
    address     = 10'h020;
    wdata       = 32'hBAD0BAD0;
    MemWrite_en = 1'b1;
    pulses      = 0;
    repeat (2) begin
      @(negedge clock);
      if (ready === 1'b1) pulses++;
    end
    reset       = 1'b1;
    MemWrite_en = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    check_output("midreset_busy", 128'(busy), 128'd0);
    for (int k = 0; k < LAT + 3; k++) begin
      @(negedge clock);
      if (ready === 1'b1) pulses++;
    end
    check_output("midreset_pulses", 128'(pulses), 128'd0);
    read_word("midreset_mem_kept", 10'h020, 0, 32'hCAFEF00D);

    // Randomized traffic over a 32-word window against an array model.
    for (int j = 0; j < 32; j++) begin
      ref_mem[j] = $urandom;
      apply_stimulus(1'b1, 1'b0, 10'h100 + 10'(j), ref_mem[j], 0, 1'b0, 1'b0,
                     lat, pulses, idle);
      check_handshake("rand_init", lat, pulses, idle);
    end
    for (int n = 0; n < 40; n++) begin
      bit          wr, rd;
      int          off, hold, gap, base;
      logic [31:0] d;
      logic [127:0] exp_line;
      off  = $urandom_range(0, 31);
      d    = $urandom;
      hold = $urandom_range(0, 3);
      gap  = $urandom_range(0, 2);
      wr   = ($urandom_range(0, 1) == 1);
      rd   = !wr || ($urandom_range(0, 3) == 0);
      apply_stimulus(wr, rd, 10'h100 + 10'(off), d, hold, 1'b0, 1'b0, lat, pulses, idle);
      check_handshake($sformatf("rand%0d", n), lat, pulses, idle);
      if (wr) begin
        ref_mem[off] = d;
      end else begin
        base = off - (off % 4);
        for (int k = 0; k < 4; k++) exp_line[k*32 +: 32] = ref_mem[base + k];
        check_output($sformatf("rand%0d_line", n), rdata_line, exp_line);
      end
      repeat (gap) @(negedge clock);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
